// File: rtl/updown_counter_modal_if.sv
// Control and status bundle for the modal up/down counter.
// The bench drives through the master view; the counter sits on the slave view.
interface updown_counter_modal_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             up_dn;
  logic [1:0]       mode;
  logic [WIDTH-1:0] Q;
  logic             dir;
  logic             tc;
  logic             evt;
  logic             done;

  modport master (
    output en, load, load_val, up_dn, mode,
    input  Q, dir, tc, evt, done
  );

  modport slave (
    input  en, load, load_val, up_dn, mode,
    output Q, dir, tc, evt, done
  );
endinterface

// File: rtl/updown_counter_modal.sv
// Modal up/down counter: wrap, saturate, ping-pong and one-shot behaviour
// between 0 and MAX_VAL, with load, sticky completion flag and event pulse.
module updown_counter_modal #(
  parameter int               WIDTH   = 3,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input logic                  clock,
  input logic                  reset,
  updown_counter_modal_if.slave bus
);

  localparam logic [1:0]       MODE_WRAP = 2'b00;
  localparam logic [1:0]       MODE_SAT  = 2'b01;
  localparam logic [1:0]       MODE_PING = 2'b10;
  localparam logic [1:0]       MODE_ONE  = 2'b11;
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO      = '0;

  logic [WIDTH-1:0] q_r;
  logic             dir_r;
  logic             evt_r;
  logic             done_r;

  logic [WIDTH-1:0] q_nxt_s;
  logic             dir_nxt_s;
  logic             evt_nxt_s;
  logic             done_nxt_s;
  logic             step_dir_s;
  logic             at_bound_s;

  // Next-state computation: load beats enable; bounds handled per mode.
  always_comb begin
    q_nxt_s    = q_r;
    dir_nxt_s  = dir_r;
    evt_nxt_s  = 1'b0;
    done_nxt_s = done_r;
    // Ping-pong follows its own remembered direction; other modes follow the request.
    if (bus.mode == MODE_PING) begin
      step_dir_s = dir_r;
    end else begin
      step_dir_s = bus.up_dn;
    end
    if (step_dir_s) begin
      at_bound_s = (q_r == MAX_VAL);
    end else begin
      at_bound_s = (q_r == ZERO);
    end

    if (bus.load) begin
      if (bus.load_val > MAX_VAL) begin
        q_nxt_s = MAX_VAL;
      end else begin
        q_nxt_s = bus.load_val;
      end
      dir_nxt_s  = bus.up_dn;
      done_nxt_s = 1'b0;
    end else if (bus.en) begin
      if (bus.mode != MODE_PING) begin
        dir_nxt_s = bus.up_dn;
      end else begin
        dir_nxt_s = dir_r;
      end
      if (done_r) begin
        // Completed one-shot freezes the count until load or reset.
        q_nxt_s = q_r;
      end else if (!at_bound_s) begin
        if (step_dir_s) begin
          q_nxt_s = q_r + ONE;
        end else begin
          q_nxt_s = q_r - ONE;
        end
      end else begin
        case (bus.mode)
          MODE_WRAP: begin
            q_nxt_s   = step_dir_s ? ZERO : MAX_VAL;
            evt_nxt_s = 1'b1;
          end
          MODE_SAT: begin
            q_nxt_s = q_r;
          end
          MODE_PING: begin
            // Reflect off the bound: next value is one step back inside the range.
            q_nxt_s   = step_dir_s ? (MAX_VAL - ONE) : ONE;
            dir_nxt_s = ~step_dir_s;
            evt_nxt_s = 1'b1;
          end
          MODE_ONE: begin
            q_nxt_s    = q_r;
            done_nxt_s = 1'b1;
            evt_nxt_s  = 1'b1;
          end
          default: begin
            q_nxt_s = q_r;
          end
        endcase
      end
    end else begin
      q_nxt_s = q_r;
    end
  end

  // State register with synchronous reset to count 0, direction up.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_r    <= ZERO;
      dir_r  <= 1'b1;
      evt_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      q_r    <= q_nxt_s;
      dir_r  <= dir_nxt_s;
      evt_r  <= evt_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  assign bus.Q    = q_r;
  assign bus.dir  = dir_r;
  assign bus.evt  = evt_r;
  assign bus.done = done_r;
  // Terminal count looks only at the registered count and direction.
  assign bus.tc   = (dir_r && (q_r == MAX_VAL)) || (!dir_r && (q_r == ZERO));

endmodule
